vend_mech_arbiter: RTL

- Round-robin arbiter/sequencer that shares one physical vending mechanism between N vending front-end FSMs.
- Each front-end requests either a product dispense or a coin return.
- The block grants one requester at a time, issues a start pulse to the mechanism, waits for completion, acknowledges the requester, then enforces a cool-down gap.
- Sits between the per-slot vending controllers and the shared dispenser/coin-return driver.

---
 rtl/vend_mech_if.sv | 25 ++
 rtl/vend_mech_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vend_mech_if.sv
// Handshake bundle between the vending front-ends, the shared mechanism driver and the arbiter.
// slave = arbiter side, master = front-end/mechanism side.
interface vend_mech_if #(
  parameter int N = 4
) ();
  logic [N-1:0] req;
  logic [N-1:0] req_ret;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         busy;
  logic         mech_start;
  logic         mech_sel;
  logic         mech_done;
  logic         fault;

  modport slave (
    input  req, req_ret, mech_done,
    output gnt, ack, busy, mech_start, mech_sel, fault
  );

  modport master (
    output req, req_ret, mech_done,
    input  gnt, ack, busy, mech_start, mech_sel, fault
  );
endinterface

// File: rtl/vend_mech_arbiter.sv
// Round-robin sequencer sharing one dispense/coin-return mechanism among N front-ends.
// Optional WAIT timeout with sticky fault flag: define VEND_MECH_TIMEOUT_EN.
module vend_mech_arbiter #(
  parameter int N           = 4,
  parameter int COOL_CYC    = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst,
  vend_mech_if.slave   bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, COOL} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [N-1:0]    ack_reg, ack_next;
  logic            sel_reg, sel_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   cool_reg, cool_next;
  logic [IW-1:0]   cand_idx [N];
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            timeout;

  // Candidate gi is the requester gi places after the pointer, wrapping at N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

  // Scan from the farthest candidate back so the nearest asserted one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[cand_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      sel_reg   <= 1'b0;
      ptr_reg   <= '0;
      cool_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      cool_reg  <= cool_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    cool_next  = cool_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          sel_next          = bus.req_ret[win_idx];
          ptr_next          = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
          state_next        = START;
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        // A timeout completes the operation exactly like mech_done would.
        if (bus.mech_done || timeout) begin
          ack_next = gnt_reg;
          gnt_next = '0;
          sel_next = 1'b0;
          if (COOL_CYC == 0) begin
            state_next = IDLE;
          end else begin
            state_next = COOL;
            cool_next  = CW'(COOL_CYC - 1);
          end
        end
      end
      COOL: begin
        if (cool_reg == '0) begin
          state_next = IDLE;
        end else begin
          cool_next = cool_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VEND_MECH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] wait_cnt_reg;
  logic          fault_reg;

  // A late mech_done on the expiry cycle still wins over the timeout.
  assign timeout = (state_reg == WAIT) && !bus.mech_done &&
                   (wait_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout) begin
        fault_reg <= 1'b1;
      end
    end
  end

  assign bus.fault = fault_reg;
`else
  assign timeout   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  assign bus.gnt        = gnt_reg;
  assign bus.ack        = ack_reg;
  assign bus.mech_sel   = sel_reg;
  assign bus.mech_start = (state_reg == START);
  assign bus.busy       = (state_reg != IDLE);

endmodule
